prog_loader: RTL

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It receives a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, and writes them to consecutive instruction-memory word addresses starting at 0. It holds the CPU in reset until the whole image is committed, then releases it so execution starts from PC 0.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_word_assembler.sv | 44 ++++
 rtl/prog_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Byte-to-word assembler: collects little-endian bytes into 32-bit words.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The 4th byte is combined directly with the three held bytes, so the word
  // is presented on the same cycle that byte is accepted.
  assign word_valid_o = byte_valid_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = {byte_i, shift_q};

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream -> instruction memory, holds CPU in reset until done.
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rstn,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER = S_CHK;
`else
  localparam state_e S_AFTER = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rstn_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] hdr_count;
  logic        last_word;

  assign in_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
  assign accept     = in_valid && in_ready;
  assign hdr_count  = {in_data, len_lo_q};
  assign last_word  = ((17'(widx_q) + 17'd1) == 17'(count_q));

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rstn   = cpu_rstn_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

  word_assembler u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (state_q != S_DATA),
    .byte_valid_i (accept && (state_q == S_DATA)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    count_d  = count_q;
    widx_d   = widx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          count_d = hdr_count;
          widx_d  = '0;
          if ({1'b0, hdr_count} > DEPTH) state_d = S_ERROR;
          else if (hdr_count == 16'd0)   state_d = S_AFTER;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ in_data;
`endif
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = widx_q[ADDR_WIDTH-1:0];
          wdata_d = word;
          widx_d  = widx_q + 1'b1;
          if (last_word) state_d = S_AFTER;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_LEN0;
      len_lo_q   <= '0;
      count_q    <= '0;
      widx_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rstn_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      widx_q     <= widx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      // Lags DONE by one edge so the final write commits before the CPU runs.
      cpu_rstn_q <= (state_q == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
